// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the data-memory access controller.
//   size_e  : load/store access size as carried on req_size_i
//   state_e : controller FSM states
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOAD = 2'b01,
      ST_RESP = 2'b10
   } state_e;

endpackage

// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: bundles the load/store request channel, the response
// channel and the RAM-side port of dmem_ctrl.
//   slave  : controller view (dmem_ctrl)
//   master : load/store unit + RAM view
// Parameter ADDR_W is the RAM byte-address width; it must equal
// $clog2(DEPTH*WIDTH) of the attached controller.
interface dmem_ctrl_if #(
   parameter int ADDR_W = 11
);
   logic              req_valid_i;
   logic              req_ready_o;
   logic              req_we_i;
   logic [1:0]        req_size_i;
   logic              req_unsigned_i;
   logic [31:0]       req_addr_i;
   logic [31:0]       req_wdata_i;
   logic              rsp_valid_o;
   logic              rsp_ready_i;
   logic [31:0]       rsp_rdata_o;
   logic              rsp_err_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [31:0]       mem_wr_data_o;
   logic [3:0]        mem_bytemask_o;
   logic              mem_write_en_o;
   logic              mem_read_en_o;
   logic [31:0]       mem_rd_data_i;

   modport slave (
      input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i,
             req_wdata_i, rsp_ready_i, mem_rd_data_i,
      output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, mem_addr_o,
             mem_wr_data_o, mem_bytemask_o, mem_write_en_o, mem_read_en_o
   );

   modport master (
      output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i,
             req_wdata_i, rsp_ready_i, mem_rd_data_i,
      input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, mem_addr_o,
             mem_wr_data_o, mem_bytemask_o, mem_write_en_o, mem_read_en_o
   );
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: purely combinational byte-lane helper.
//   i_size, i_off, i_unsigned : access descriptor (offset = addr[1:0])
//   i_wdata  -> o_wdata  : right-aligned store data replicated across lanes
//   o_mask               : byte-lane enables for the access
//   o_misalign           : half at odd offset, word at nonzero offset, or reserved size
//   i_rdata  -> o_rdata  : RAM word shifted to the access offset, extracted and extended
// Reserved size is treated as word and misaligned offsets are forced to
// natural alignment; the caller decides whether o_misalign traps instead.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   input  logic [1:0]  i_off,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_mask,
   output logic [31:0] o_wdata,
   output logic        o_misalign,
   output logic [31:0] o_rdata
);
   logic [1:0]  w_off;
   logic [31:0] w_shift;

   // Lane mask, store replication, misalign detect and load extract/extend
   always_comb begin
      w_off      = 2'b00;
      o_mask     = 4'h0;
      o_wdata    = 32'h0000_0000;
      o_misalign = 1'b0;
      o_rdata    = 32'h0000_0000;
      w_shift    = 32'h0000_0000;
      case (i_size)
         SZ_BYTE: begin
            w_off      = i_off;
            o_mask     = 4'b0001 << i_off;
            o_wdata    = {4{i_wdata[7:0]}};
            o_misalign = 1'b0;
         end
         SZ_HALF: begin
            w_off      = {i_off[1], 1'b0};
            o_mask     = 4'b0011 << {i_off[1], 1'b0};
            o_wdata    = {2{i_wdata[15:0]}};
            o_misalign = i_off[0];
         end
         SZ_WORD: begin
            w_off      = 2'b00;
            o_mask     = 4'hF;
            o_wdata    = i_wdata;
            o_misalign = (i_off != 2'b00);
         end
         default: begin
            // reserved size behaves as a word access when it is not trapped
            w_off      = 2'b00;
            o_mask     = 4'hF;
            o_wdata    = i_wdata;
            o_misalign = 1'b1;
         end
      endcase
      w_shift = i_rdata >> {w_off, 3'b000};
      case (i_size)
         SZ_BYTE: o_rdata = i_unsigned ? {24'h00_0000, w_shift[7:0]}
                                       : {{24{w_shift[7]}}, w_shift[7:0]};
         SZ_HALF: o_rdata = i_unsigned ? {16'h0000, w_shift[15:0]}
                                       : {{16{w_shift[15]}}, w_shift[15:0]};
         default: o_rdata = w_shift;
      endcase
   end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory access controller between the load/store unit and
// a byte-lane RAM with one-cycle registered read latency.
//   clk      : single clock, rising edge
//   rst_n_i  : asynchronous active-low reset
//   bus      : dmem_ctrl_if.slave (request, response and RAM ports)
// Parameters: DEPTH (RAM words), WIDTH (bytes per word, must be 4).
// Optional build macro DMEM_MISALIGN_TRAP_EN: misaligned / reserved-size
// requests are answered with rsp_err_o instead of being force-aligned.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int DEPTH = 512,
   parameter int WIDTH = 4
) (
   input  logic       clk,
   input  logic       rst_n_i,
   dmem_ctrl_if.slave bus
);
   localparam int ADDR_W = $clog2(DEPTH * WIDTH);

   if (WIDTH != 4) begin : g_width_check
      $error("dmem_ctrl: WIDTH must be 4");
   end

   state_e      r_state;
   logic [1:0]  r_off;
   logic [1:0]  r_size;
   logic        r_uns;
   logic [31:0] r_rdata;
   logic        r_err;
   logic        r_valid;

   logic        w_accept;
   logic        w_trap;
   logic        w_wr_en;
   logic        w_rd_en;
   logic [3:0]  w_mask;
   logic [3:0]  w_req_mask;
   logic [31:0] w_req_wdata;
   logic        w_req_misalign;
   logic [31:0] w_ld_rdata;

   logic [3:0]         w_unused_ld_mask;
   logic [31:0]        w_unused_ld_wdata;
   logic               w_unused_ld_misalign;
   logic [31:0]        w_unused_req_rdata;
   logic [31-ADDR_W:0] w_unused_addr_hi;

   dmem_lane_align u_req_align (
      .i_size     (bus.req_size_i),
      .i_unsigned (bus.req_unsigned_i),
      .i_off      (bus.req_addr_i[1:0]),
      .i_wdata    (bus.req_wdata_i),
      .i_rdata    (32'h0000_0000),
      .o_mask     (w_req_mask),
      .o_wdata    (w_req_wdata),
      .o_misalign (w_req_misalign),
      .o_rdata    (w_unused_req_rdata)
   );

   dmem_lane_align u_ld_align (
      .i_size     (r_size),
      .i_unsigned (r_uns),
      .i_off      (r_off),
      .i_wdata    (32'h0000_0000),
      .i_rdata    (bus.mem_rd_data_i),
      .o_mask     (w_unused_ld_mask),
      .o_wdata    (w_unused_ld_wdata),
      .o_misalign (w_unused_ld_misalign),
      .o_rdata    (w_ld_rdata)
   );

`ifdef DMEM_MISALIGN_TRAP_EN
   assign w_trap = w_req_misalign;
`else
   logic w_unused_misalign;
   assign w_unused_misalign = w_req_misalign;
   assign w_trap            = 1'b0;
`endif

   // upper address bits only select aliases of the RAM
   assign w_unused_addr_hi = bus.req_addr_i[31:ADDR_W];

   // Accept qualification; reset drops the strobes without waiting for a clock
   always_comb begin
      w_accept = 1'b0;
      if (rst_n_i && bus.req_valid_i && (r_state == ST_IDLE)) begin
         w_accept = 1'b1;
      end else begin
         w_accept = 1'b0;
      end
   end

   // RAM strobes exist only in the accept cycle of a non-trapped request
   always_comb begin
      w_wr_en = 1'b0;
      w_rd_en = 1'b0;
      w_mask  = 4'h0;
      if (w_accept && !w_trap) begin
         if (bus.req_we_i) begin
            w_wr_en = 1'b1;
            w_mask  = w_req_mask;
         end else begin
            w_rd_en = 1'b1;
            w_mask  = 4'h0;
         end
      end else begin
         w_wr_en = 1'b0;
         w_rd_en = 1'b0;
         w_mask  = 4'h0;
      end
   end

   // Control FSM with registered response channel
   always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= ST_IDLE;
         r_off   <= 2'b00;
         r_size  <= 2'b00;
         r_uns   <= 1'b0;
         r_rdata <= 32'h0000_0000;
         r_err   <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_rdata <= 32'h0000_0000;
                  r_err   <= w_trap;
                  if (w_trap || bus.req_we_i) begin
                     r_state <= ST_RESP;
                     r_valid <= 1'b1;
                  end else begin
                     r_state <= ST_LOAD;
                     r_off   <= bus.req_addr_i[1:0];
                     r_size  <= bus.req_size_i;
                     r_uns   <= bus.req_unsigned_i;
                  end
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_LOAD: begin
               // RAM read word is present this cycle
               r_rdata <= w_ld_rdata;
               r_valid <= 1'b1;
               r_state <= ST_RESP;
            end
            ST_RESP: begin
               if (bus.rsp_ready_i) begin
                  r_valid <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_state <= ST_RESP;
               end
            end
            default: begin
               r_valid <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready_o    = (r_state == ST_IDLE);
   assign bus.rsp_valid_o    = r_valid;
   assign bus.rsp_rdata_o    = r_rdata;
   assign bus.rsp_err_o      = r_err;
   assign bus.mem_addr_o     = bus.req_addr_i[ADDR_W-1:0];
   assign bus.mem_wr_data_o  = w_req_wdata;
   assign bus.mem_bytemask_o = w_mask;
   assign bus.mem_write_en_o = w_wr_en;
   assign bus.mem_read_en_o  = w_rd_en;
endmodule
